lock_entry_ctrl: RTL and testbench
==================================

LOCK_ENTRY_CTRL -- requirements
Module: lock_entry_ctrl

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 3, consecutive wrong codes that trigger lockout (>=1).
REQ-002 SHALL have parameter UNLOCK_CYCLES, default 8, cycles unlock stays high after a correct code (>=1).
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 16, cycles alarm stays high during lockout (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port keyValid, input, 1, one-cycle strobe qualifying keyDigit.
REQ-007 SHALL have port keyDigit, input, 4, entered digit (any 4-bit value accepted).
REQ-008 SHALL have port enterKey, input, 1, one-cycle submit strobe.
REQ-009 SHALL have port changeKey, input, 1, one-cycle strobe requesting a password change.
REQ-010 SHALL have port lockPass, input, 32, stored password read from the downstream lock register.
REQ-011 SHALL have port lockBuffer, output, 32, new password presented to the lock register.
REQ-012 SHALL have port readLock, output, 1, 1 = lock read-only, 0 = lock accepts lockBuffer.
REQ-013 SHALL have port unlock, output, 1, high while open.
REQ-014 SHALL have port alarm, output, 1, high during lockout.
REQ-015 SHALL have port digitCount, output, 4, digits held in the entry register (0..8).

Function
REQ-016 SHALL implement states IDLE, ENTRY, CHECK, OPEN, CHG_NEW, WR_SETUP, WR_DATA, WR_DONE, LOCKOUT; all outputs registered.
REQ-017 Digit capture SHALL shift entryReg <= {entryReg[27:0], keyDigit} and increment digitCount; entryReg and digitCount clear on entering ENTRY-from-IDLE, CHG_NEW and CHECK exit; short codes are therefore zero-padded on the left.
REQ-018 keyValid with digitCount==8 SHALL be ignored (no shift, no count change).
REQ-019 IDLE: keyValid -> capture, go ENTRY; enterKey and changeKey ignored.
REQ-020 ENTRY: keyValid -> capture; enterKey -> CHECK; keyValid and enterKey in the same cycle: enterKey wins, digit dropped.
REQ-021 CHECK (exactly 1 cycle): entryReg==lockPass -> OPEN, fail counter=0; else fail counter+1, go LOCKOUT if it reaches MAX_TRIES, else IDLE.
REQ-022 OPEN: unlock=1 from the cycle after CHECK for UNLOCK_CYCLES cycles, then IDLE with unlock=0; changeKey while OPEN -> CHG_NEW, unlock=0 next cycle.
REQ-023 CHG_NEW: keyValid -> capture; enterKey with digitCount>=1 -> WR_SETUP; enterKey with digitCount==0 ignored; same-cycle priority as REQ-020.
REQ-024 WR_SETUP (1 cycle): readLock=0, lockBuffer unchanged.
REQ-025 WR_DATA (1 cycle): readLock=0, lockBuffer=entryReg (updated on entry to WR_DATA, one cycle after readLock fell).
REQ-026 WR_DONE (1 cycle): readLock=1, lockBuffer held; then IDLE; lockBuffer SHALL change only on entry to WR_DATA or reset.
REQ-027 Writing a password equal to the current lockBuffer SHALL complete the sequence normally (no event downstream, value already stored).
REQ-028 LOCKOUT: alarm=1 for LOCKOUT_CYCLES cycles, all key inputs ignored; on exit fail counter=0, alarm=0, IDLE.
REQ-029 Cycle timer SHALL be sized for max(UNLOCK_CYCLES, LOCKOUT_CYCLES), reload on each state entry, never wrap.
REQ-030 Fail counter SHALL saturate at MAX_TRIES and is not cleared by a change sequence.

Reset
REQ-031 reset SHALL take priority over all inputs; next cycle: state IDLE, lockBuffer=0, readLock=1, unlock=0, alarm=0, digitCount=0, entryReg=0, fail counter=0, timer=0.
REQ-032 reset during WR_SETUP/WR_DATA/WR_DONE SHALL abort the write, driving readLock=1 and lockBuffer=0 on the same edge.

Verification
REQ-033 After reset, lockPass=0: keys 1,2,3,4, enterKey -> CHECK fails (0x00001234 != 0), fail counter=1, unlock stays 0.
REQ-034 lockPass=0x00001234: keys 1,2,3,4, enterKey -> unlock=1 for exactly 8 cycles starting 2 cycles after enterKey.
REQ-035 While OPEN: changeKey, keys 9,8, enterKey -> readLock 0 for 2 cycles, lockBuffer=0x00000098 in second, readLock=1 after.
REQ-036 Three wrong codes -> alarm=1 for 16 cycles, keyValid/enterKey ignored throughout, then IDLE with fail counter=0.
REQ-037 Nine digits then enterKey -> 9th ignored, digitCount=8; keyValid+enterKey same cycle -> digit dropped, CHECK entered.
REQ-038 reset asserted in WR_DATA -> next cycle readLock=1, lockBuffer=0, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/lock_entry_ctrl_if.sv
// Keypad and lock-register signals between the entry controller (slave)
// and its environment (master).
interface lock_entry_ctrl_if;
    logic        keyValid;
    logic [3:0]  keyDigit;
    logic        enterKey;
    logic        changeKey;
    logic [31:0] lockPass;
    logic [31:0] lockBuffer;
    logic        readLock;
    logic        unlock;
    logic        alarm;
    logic [3:0]  digitCount;

    modport master (
        output keyValid, keyDigit, enterKey, changeKey, lockPass,
        input  lockBuffer, readLock, unlock, alarm, digitCount
    );

    modport slave (
        input  keyValid, keyDigit, enterKey, changeKey, lockPass,
        output lockBuffer, readLock, unlock, alarm, digitCount
    );
endinterface

// File: rtl/lock_entry_ctrl.sv
// Keypad lock controller: code entry and check, timed unlock, password
// change through a three-cycle lock-register write, and timed lockout.
module lock_entry_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    lock_entry_ctrl_if.slave bus
);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_TRIES + 1);

    localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_TRIES);

    typedef enum logic [3:0] {
        IDLE, ENTRY, CHECK, OPEN, CHG_NEW, WR_SETUP, WR_DATA, WR_DONE, LOCKOUT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   entry_q, entry_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d, fail_inc;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   lock_buf_q, lock_buf_d;
    logic          read_lock_q, read_lock_d;
    logic          unlock_q, unlock_d;
    logic          alarm_q, alarm_d;
    logic          capture;

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        cnt_d       = cnt_q;
        fail_d      = fail_q;
        timer_d     = (timer_q != '0) ? timer_q - 1'b1 : '0;
        lock_buf_d  = lock_buf_q;
        read_lock_d = read_lock_q;
        unlock_d    = unlock_q;
        alarm_d     = alarm_q;
        fail_inc    = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;
        capture     = bus.keyValid && (cnt_q != 4'd8);

        case (state_q)
            IDLE: begin
                // First digit lands in a freshly cleared register.
                if (bus.keyValid) begin
                    state_d = ENTRY;
                    entry_d = {28'd0, bus.keyDigit};
                    cnt_d   = 4'd1;
                    timer_d = '0;
                end
            end
            ENTRY: begin
                if (bus.enterKey) begin
                    state_d = CHECK;
                    timer_d = '0;
                end else if (capture) begin
                    entry_d = {entry_q[27:0], bus.keyDigit};
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if (entry_q == bus.lockPass) begin
                    state_d  = OPEN;
                    fail_d   = '0;
                    unlock_d = 1'b1;
                    timer_d  = T_UNLOCK;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        state_d = LOCKOUT;
                        alarm_d = 1'b1;
                        timer_d = T_LOCK;
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end
            end
            OPEN: begin
                if (bus.changeKey) begin
                    state_d  = CHG_NEW;
                    unlock_d = 1'b0;
                    entry_d  = '0;
                    cnt_d    = '0;
                    timer_d  = '0;
                end else if (timer_q == '0) begin
                    state_d  = IDLE;
                    unlock_d = 1'b0;
                end
            end
            CHG_NEW: begin
                if (bus.enterKey) begin
                    if (cnt_q != 4'd0) begin
                        state_d     = WR_SETUP;
                        read_lock_d = 1'b0;
                        timer_d     = '0;
                    end
                end else if (capture) begin
                    entry_d = {entry_q[27:0], bus.keyDigit};
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            // Data follows the write enable by one cycle so the register sees a setup cycle.
            WR_SETUP: begin
                state_d    = WR_DATA;
                lock_buf_d = entry_q;
            end
            WR_DATA: begin
                state_d     = WR_DONE;
                read_lock_d = 1'b1;
            end
            WR_DONE: state_d = IDLE;
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    alarm_d = 1'b0;
                    fail_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            cnt_q       <= '0;
            fail_q      <= '0;
            timer_q     <= '0;
            lock_buf_q  <= '0;
            read_lock_q <= 1'b1;
            unlock_q    <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            fail_q      <= fail_d;
            timer_q     <= timer_d;
            lock_buf_q  <= lock_buf_d;
            read_lock_q <= read_lock_d;
            unlock_q    <= unlock_d;
            alarm_q     <= alarm_d;
        end
    end

    assign bus.lockBuffer = lock_buf_q;
    assign bus.readLock   = read_lock_q;
    assign bus.unlock     = unlock_q;
    assign bus.alarm      = alarm_q;
    assign bus.digitCount = cnt_q;
endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Bench for lock_entry_ctrl: directed scenarios plus a scoreboard of expected
// unlock/alarm pulse lengths and lock-register write transactions.
module tb_lock_entry_ctrl;
    localparam int EV_UNLOCK = 0;
    localparam int EV_ALARM  = 1;
    localparam int EV_WRITE  = 2;

    typedef struct {
        int          kind;
        int          len;
        logic [31:0] val;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];

    int          mon_un = 0;
    int          mon_al = 0;
    int          mon_rl = 0;
    logic [31:0] mon_val = '0;

    lock_entry_ctrl_if bus();

    lock_entry_ctrl #(
        .MAX_TRIES(3), .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input int len, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.len  = len;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input int len, input logic [31:0] val);
        ev_t e;
        chk("sb_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("sb_kind", kind, e.kind);
        chk("sb_len", len, e.len);
        if (kind == EV_WRITE) chk("sb_wval", val, e.val);
    endtask

    // Output monitor: measures pulse lengths at the falling clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.unlock === 1'b1) mon_un++;
            else if (mon_un != 0) begin sb_pop(EV_UNLOCK, mon_un, '0); mon_un = 0; end
            if (bus.alarm === 1'b1) mon_al++;
            else if (mon_al != 0) begin sb_pop(EV_ALARM, mon_al, '0); mon_al = 0; end
            if (bus.readLock === 1'b0) begin
                mon_rl++;
                mon_val = bus.lockBuffer;
            end else if (mon_rl != 0) begin
                sb_pop(EV_WRITE, mon_rl, mon_val);
                mon_rl = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        bus.keyValid = 1'b1;
        bus.keyDigit = d;
        tick();
        bus.keyValid = 1'b0;
    endtask

    task automatic enter();
        bus.enterKey = 1'b1;
        tick();
        bus.enterKey = 1'b0;
    endtask

    task automatic chg();
        bus.changeKey = 1'b1;
        tick();
        bus.changeKey = 1'b0;
    endtask

    task automatic key_enter(input logic [3:0] d);
        bus.keyValid = 1'b1;
        bus.keyDigit = d;
        bus.enterKey = 1'b1;
        tick();
        bus.keyValid = 1'b0;
        bus.enterKey = 1'b0;
    endtask

    task automatic enter_code(input logic [31:0] code, input int n);
        for (int i = n - 1; i >= 0; i--) key(code[i*4 +: 4]);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_lb"}, bus.lockBuffer, 32'h0);
        chk({tag, "_rl"}, 32'(bus.readLock), 32'd1);
        chk({tag, "_un"}, 32'(bus.unlock), 32'd0);
        chk({tag, "_al"}, 32'(bus.alarm), 32'd0);
        chk({tag, "_dc"}, 32'(bus.digitCount), 32'd0);
    endtask

    task automatic wait_unlock_low();
        for (int i = 0; i < 40 && bus.unlock !== 1'b0; i++) tick();
        chk("unlock_timeout", 32'(bus.unlock), 32'd0);
    endtask

    task automatic wait_alarm_low();
        for (int i = 0; i < 40 && bus.alarm !== 1'b0; i++) tick();
        chk("alarm_timeout", 32'(bus.alarm), 32'd0);
    endtask

    // Enter code, leave the machine in OPEN (unlock just rose).
    task automatic open_with(input logic [31:0] code, input int n);
        enter_code(code, n);
        enter();
        tick();
        chk("open_un", 32'(bus.unlock), 32'd1);
    endtask

    task automatic do_change(input logic [31:0] code, input int n);
        chg();
        chk("chg_un", 32'(bus.unlock), 32'd0);
        enter();
        tick();
        chk("chg_empty_enter", 32'(bus.readLock), 32'd1);
        enter_code(code, n);
        push(EV_WRITE, 2, code);
        enter();
        chk("wr_setup_rl", 32'(bus.readLock), 32'd0);
        tick();
        chk("wr_data_rl", 32'(bus.readLock), 32'd0);
        chk("wr_data_lb", bus.lockBuffer, code);
        tick();
        chk("wr_done_rl", 32'(bus.readLock), 32'd1);
        chk("wr_done_lb", bus.lockBuffer, code);
        tick();
    endtask

    initial begin
        bus.keyValid  = 1'b0;
        bus.keyDigit  = 4'h0;
        bus.enterKey  = 1'b0;
        bus.changeKey = 1'b0;
        bus.lockPass  = 32'h0;
        reset = 1'b1;
        repeat (3) tick();
        chk_reset_outs("rst");
        reset = 1'b0;

        // Wrong code against an all-zero password.
        enter_code(32'h1234, 4);
        chk("dc4", 32'(bus.digitCount), 32'd4);
        enter();
        tick();
        chk("bad_un", 32'(bus.unlock), 32'd0);
        chk("bad_dc", 32'(bus.digitCount), 32'd0);

        // Correct code: unlock rises two cycles after the enter strobe, 8 cycles long.
        bus.lockPass = 32'h0000_1234;
        push(EV_UNLOCK, 8, '0);
        enter_code(32'h1234, 4);
        enter();
        chk("check_un", 32'(bus.unlock), 32'd0);
        tick();
        chk("open_un1", 32'(bus.unlock), 32'd1);
        wait_unlock_low();

        // Password change to 98, then rewrite of the same value.
        push(EV_UNLOCK, 1, '0);
        open_with(32'h1234, 4);
        do_change(32'h98, 2);
        bus.lockPass = 32'h98;
        push(EV_UNLOCK, 1, '0);
        open_with(32'h98, 2);
        do_change(32'h98, 2);

        // Three wrong codes into lockout; keys ignored during it.
        for (int t = 0; t < 3; t++) begin
            key(4'h5);
            enter();
            if (t == 2) push(EV_ALARM, 16, '0);
            tick();
        end
        chk("lock_al", 32'(bus.alarm), 32'd1);
        bus.keyValid  = 1'b1;
        bus.keyDigit  = 4'hF;
        bus.enterKey  = 1'b1;
        bus.changeKey = 1'b1;
        repeat (10) tick();
        bus.keyValid  = 1'b0;
        bus.enterKey  = 1'b0;
        bus.changeKey = 1'b0;
        chk("lock_dc", 32'(bus.digitCount), 32'd0);
        chk("lock_al_hold", 32'(bus.alarm), 32'd1);
        wait_alarm_low();
        key(4'h5);
        enter();
        tick();
        chk("post_lock_al", 32'(bus.alarm), 32'd0);

        // Ninth digit ignored: 8 digits must match the stored code.
        bus.lockPass = 32'h1234_5678;
        enter_code(32'h1234_5678, 8);
        chk("dc8", 32'(bus.digitCount), 32'd8);
        key(4'h9);
        chk("dc8_hold", 32'(bus.digitCount), 32'd8);
        push(EV_UNLOCK, 8, '0);
        enter();
        tick();
        chk("nine_un", 32'(bus.unlock), 32'd1);
        wait_unlock_low();

        // Digit and enter together: digit dropped.
        bus.lockPass = 32'h12;
        push(EV_UNLOCK, 8, '0);
        key(4'h1);
        key(4'h2);
        key_enter(4'h3);
        chk("same_dc", 32'(bus.digitCount), 32'd2);
        tick();
        chk("same_un", 32'(bus.unlock), 32'd1);
        wait_unlock_low();

        // Reset during WR_DATA aborts the write.
        push(EV_UNLOCK, 1, '0);
        open_with(32'h12, 2);
        chg();
        key(4'h7);
        push(EV_WRITE, 2, 32'h7);
        enter();
        tick();
        chk("abort_lb", bus.lockBuffer, 32'h7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outs("abort");
        key(4'h3);
        chk("abort_idle_dc", 32'(bus.digitCount), 32'd1);

        repeat (3) tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
